layer_serializer: RTL and testbench

- Sits directly downstream of a fully-parallel nn_layer and feeds the next layer.
- Waits until every neuron of the producing layer has asserted its valid, then captures the packed output bus.
- Streams the captured values one word per handshake, together with the matching weight address, as the serial data_in / input_valid / local_addr stream the next layer consumes.
- Rate-decouples the layers with a ready/valid handshake.

---
 rtl/nn_pkg.sv | 15 +
 rtl/layer_serializer_argmax.sv | 56 +++++
 rtl/layer_serializer.sv | 124 ++++++++++++
 tb/tb_layer_serializer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: definitions shared by the layer serializer and its neighbours.
//   ser_state_e : serializer FSM state (IDLE waits for a frame, STREAM emits it)
//   DATA_W_DEF  : default neuron output word width
//   ADDR_W      : width of the weight-memory local_addr driven by the serializer
package nn_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ser_state_e;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W     = 32;

endpackage

// File: rtl/layer_serializer_argmax.sv
// argmax_tracker: running signed maximum over the words accepted in one frame.
//   clk, rst        : clock, synchronous active-low reset
//   acc_i           : a word is accepted this cycle
//   last_i          : the accepted word is the last of the frame
//   data_i, idx_i   : accepted word and its index within the frame
//   argmax_idx_o    : index of the largest word of the last completed frame
//   argmax_valid_o  : one-cycle pulse, aligned with the frame_done pulse
module argmax_tracker import nn_pkg::*; #(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int IDX_W      = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  acc_i,
  input  logic                  last_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [IDX_W-1:0]      idx_i,
  output logic [IDX_W-1:0]      argmax_idx_o,
  output logic                  argmax_valid_o
);

  logic signed [DATA_WIDTH-1:0] max_q;
  logic [IDX_W-1:0]             best_q, res_q;
  logic                         vld_q;
  logic                         take;
  logic [IDX_W-1:0]             win_idx;

  // Index 0 always seeds the running max; strict '>' keeps the lowest index on ties.
  assign take    = (idx_i == '0) || ($signed(data_i) > max_q);
  assign win_idx = take ? idx_i : best_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      max_q  <= '0;
      best_q <= '0;
      res_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (acc_i) begin
        if (take) begin
          max_q  <= $signed(data_i);
          best_q <= idx_i;
        end
        if (last_i) begin
          res_q <= win_idx;
          vld_q <= 1'b1;
        end
      end
    end
  end

  assign argmax_idx_o   = res_q;
  assign argmax_valid_o = vld_q;

endmodule

// File: rtl/layer_serializer.sv
// layer_serializer: captures a fully-parallel layer output once every neuron
// is valid and streams it word by word (with its weight address) to the next layer.
//   clk, rst    : clock, synchronous active-low reset
//   in_valids   : per-neuron valids; a frame starts on the rising edge of their AND
//   in_data     : packed layer output, word k at in_data[k*DATA_WIDTH +: DATA_WIDTH]
//   out_ready   : downstream accepts the current word
//   out_data    : current word, out_valid : word/address valid
//   out_addr    : index of the current word, zero-extended to ADDR_W
//   busy        : a frame is being streamed
//   frame_done  : one-cycle pulse after the last word is accepted
//   overrun     : sticky, a frame arrived while busy (cleared by reset only)
// Optional (LAYER_SERIALIZER_ARGMAX_EN): argmax_idx / argmax_valid report the
// index of the largest signed word of each frame, pulsing with frame_done.
module layer_serializer import nn_pkg::*; #(
  parameter int NUM_NEURONS = 128,
  parameter int DATA_WIDTH  = DATA_W_DEF,
  parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NEURONS-1:0]            in_valids,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  output logic [ADDR_W-1:0]                 out_addr,
  output logic                              busy,
  output logic                              frame_done,
  output logic                              overrun
`ifdef LAYER_SERIALIZER_ARGMAX_EN
  ,
  output logic [IDX_W-1:0]                  argmax_idx,
  output logic                              argmax_valid
`endif
);

  ser_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0] cap_q, cap_d;
  logic all_prev_q;
  logic frame_done_q, frame_done_d;
  logic overrun_q, overrun_d;

  logic all_valid, trigger, hs, last;

  // Edge detect so a level-held all-valid starts only one frame.
  assign all_valid = &in_valids;
  assign trigger   = all_valid & ~all_prev_q;
  assign hs        = (state_q == STREAM) & out_ready;
  assign last      = (idx_q == IDX_W'(NUM_NEURONS - 1));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cap_d        = cap_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          cap_d   = in_data;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        // A frame arriving mid-stream is dropped; the current frame is untouched.
        if (trigger) overrun_d = 1'b1;
        if (hs) begin
          if (last) begin
            idx_d        = '0;
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cap_q        <= '0;
      all_prev_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cap_q        <= cap_d;
      all_prev_q   <= all_valid;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_valid  = (state_q == STREAM);
  assign out_data   = out_valid ? cap_q[idx_q] : '0;
  assign out_addr   = ADDR_W'(idx_q);
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

`ifdef LAYER_SERIALIZER_ARGMAX_EN
  argmax_tracker #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_argmax (
    .clk            (clk),
    .rst            (rst),
    .acc_i          (hs),
    .last_i         (last),
    .data_i         (out_data),
    .idx_i          (idx_q),
    .argmax_idx_o   (argmax_idx),
    .argmax_valid_o (argmax_valid)
  );
`endif

endmodule

// File: tb/tb_layer_serializer.sv
module tb_layer_serializer;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      in_valids;
  logic [N*DW-1:0]   in_data;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic [31:0]       out_addr;
  logic              busy, frame_done, overrun;
`ifdef LAYER_SERIALIZER_ARGMAX_EN
  logic [IW-1:0]     argmax_idx;
  logic              argmax_valid;
`endif

  layer_serializer #(.NUM_NEURONS(N), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valids  (in_valids),
    .in_data    (in_data),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_addr   (out_addr),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
`ifdef LAYER_SERIALIZER_ARGMAX_EN
    ,
    .argmax_idx   (argmax_idx),
    .argmax_valid (argmax_valid)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of words plus a read position.
  bit           m_busy, m_prev, m_over, m_done;
  int           m_pos, m_amax;
  logic [DW-1:0] m_words [N];

  function automatic int ref_argmax();
    int best = 0;
    for (int i = 1; i < N; i++)
      if ($signed(m_words[i]) > $signed(m_words[best])) best = i;
    return best;
  endfunction

  task automatic model_update(bit r, logic [N-1:0] v, logic [N*DW-1:0] d, bit rdy);
    bit allv, trig;
    allv = &v;
    trig = allv && !m_prev;
    if (!r) begin
      m_busy = 0; m_prev = 0; m_over = 0; m_done = 0; m_pos = 0; m_amax = 0;
      for (int k = 0; k < N; k++) m_words[k] = '0;
      return;
    end
    m_done = 0;
    if (m_busy) begin
      if (trig) m_over = 1;
      if (rdy) begin
        if (m_pos == N - 1) begin
          m_busy = 0; m_pos = 0; m_done = 1; m_amax = ref_argmax();
        end else m_pos++;
      end
    end else if (trig) begin
      for (int k = 0; k < N; k++) m_words[k] = d[k*DW +: DW];
      m_busy = 1; m_pos = 0;
    end
    m_prev = allv;
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(out_valid), 64'(m_busy));
    chk("out_data", 64'(out_data), m_busy ? 64'(m_words[m_pos]) : 64'd0);
    chk("out_addr", 64'(out_addr), m_busy ? 64'(m_pos) : 64'd0);
    chk("busy", 64'(busy), 64'(m_busy));
    chk("frame_done", 64'(frame_done), 64'(m_done));
    chk("overrun", 64'(overrun), 64'(m_over));
`ifdef LAYER_SERIALIZER_ARGMAX_EN
    chk("argmax_valid", 64'(argmax_valid), 64'(m_done));
    chk("argmax_idx", 64'(argmax_idx), 64'(m_amax));
`endif
  endtask

  // Check the cycle's outputs, then present the next inputs.
  task automatic step(bit r, logic [N-1:0] v, logic [N*DW-1:0] d, bit rdy);
    @(negedge clk);
    check_outputs();
    rst = r; in_valids = v; in_data = d; out_ready = rdy;
    model_update(r, v, d, rdy);
  endtask

  function automatic logic [N*DW-1:0] pk(int w0, int w1, int w2, int w3);
    return {DW'(w3), DW'(w2), DW'(w1), DW'(w0)};
  endfunction

  localparam logic [N-1:0] ALL = '1;
  localparam logic [N-1:0] NONE = '0;

  initial begin
    logic [N*DW-1:0] d, rd;
    logic [N-1:0]    rv;
    int              guard;
    bit              pat [4];
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;

    rst = 0; in_valids = '0; in_data = '0; out_ready = 0;
    model_update(0, '0, '0, 0);
    step(0, NONE, '0, 0);
    step(0, NONE, '0, 0);

    // basic frame
    d = pk(5, -3, 7, 2);
    step(1, NONE, d, 1);
    repeat (8) step(1, ALL, d, 1);

    // level-held valids: one frame only
    step(1, NONE, d, 1);
    repeat (20) step(1, ALL, d, 1);

    // backpressure
    step(1, NONE, d, 1);
    step(1, ALL, d, 1);
    for (int i = 0; i < 16; i++) step(1, ALL, d, pat[i % 4]);

    // overrun: re-raise all_valid during the stream
    step(1, NONE, d, 1);
    step(1, ALL, d, 1);
    step(1, NONE, pk(9, 9, 9, 9), 1);
    step(1, ALL, pk(9, 9, 9, 9), 1);
    repeat (8) step(1, NONE, d, 1);
    chk("overrun_sticky", 64'(overrun), 64'd1);

    // reset during word 2
    step(0, NONE, d, 1);
    step(1, NONE, d, 1);
    step(1, ALL, d, 1);
    guard = 0;
    while (!(m_busy && m_pos == 2) && guard < 10) begin
      step(1, ALL, d, 1);
      guard++;
    end
    chk("reach_word2", 64'(guard < 10), 64'd1);
    step(0, ALL, d, 1);
    step(1, NONE, d, 1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_addr", 64'(out_addr), 64'd0);
    repeat (8) step(1, ALL, pk(1, 2, 3, 4), 1);

    // back-to-back: new trigger in the frame_done cycle
    step(1, NONE, d, 1);
    step(1, ALL, d, 1);
    repeat (14) step(1, m_done ? ALL : NONE, pk(-4, 11, 0, 11), 1);

    // tie / negative words
    step(1, NONE, d, 1);
    repeat (8) step(1, ALL, pk(-8, -1, -1, -5), 1);

    // randomized traffic
    rv = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) rd[k*DW +: DW] = DW'($urandom);
      if ($urandom_range(0, 5) == 0)
        rv = ($urandom_range(0, 1) == 1) ? ALL : N'($urandom);
      step($urandom_range(0, 149) != 0, rv, rd, $urandom_range(0, 3) != 0);
    end
    step(1, NONE, '0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
